// File: rtl/gps_sample_packer_if.sv
// Sample/word bus of the GPS sample packer: I/Q strobe in, buffered 16-bit words and overflow status out.
interface gps_sample_packer_if;
  logic        GO_NEWDATA;
  logic        GPS_I0;
  logic        GPS_I1;
  logic        GPS_Q0;
  logic        GPS_Q1;
  logic [15:0] WORD_DATA;
  logic        WORD_VALID;
  logic        WORD_READY;
  logic        OVERFLOW;
  logic [7:0]  DROP_COUNT;

  // Packer side
  modport slave (
    input  GO_NEWDATA, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, WORD_READY,
    output WORD_DATA, WORD_VALID, OVERFLOW, DROP_COUNT
  );

  // Front-end / SPI consumer side
  modport master (
    output GO_NEWDATA, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, WORD_READY,
    input  WORD_DATA, WORD_VALID, OVERFLOW, DROP_COUNT
  );
endinterface

// File: rtl/gps_sample_packer.sv
// Packs four 2-bit I/Q nibbles per 16-bit word (first sample in the MSBs) into a small
// never-stalling FIFO; words that find the FIFO full are dropped and counted.
module gps_sample_packer #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic                MCU_CLK_25_000,
  input  logic                RST,
  gps_sample_packer_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_INC = 1;

  typedef enum logic {FILL, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [15:0]        word_q, word_d;
  logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;
  logic [15:0]        mem_q [DEPTH];

  logic [3:0] nibble;
  logic       empty, full, pop, wr_en, drop;

  assign nibble = {bus.GPS_I1, bus.GPS_I0, bus.GPS_Q1, bus.GPS_Q0};
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop    = !empty && bus.WORD_READY;

  // A pop in the commit cycle frees the slot, so a full FIFO only drops without one.
  assign wr_en  = (state_q == COMMIT) && (!full || pop);
  assign drop   = (state_q == COMMIT) && full && !pop;

  always_comb begin
    state_d = FILL;
    slot_d  = slot_q;
    word_d  = word_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;

    if (bus.GO_NEWDATA) begin
      unique case (slot_q)
        2'd0: word_d[15:12] = nibble;
        2'd1: word_d[11:8]  = nibble;
        2'd2: word_d[7:4]   = nibble;
        2'd3: word_d[3:0]   = nibble;
      endcase
      slot_d = slot_q + 2'd1;
      if (slot_q == 2'd3) state_d = COMMIT;
    end

    if (wr_en) wptr_d = wptr_q + PTR_INC;
    if (pop)   rptr_d = rptr_q + PTR_INC;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge MCU_CLK_25_000 or posedge RST) begin
    if (RST) begin
      state_q <= FILL;
      slot_q  <= '0;
      word_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      word_q  <= word_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: the cleared pointers mark every entry empty.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (wr_en) mem_q[wptr_q[FIFO_AW-1:0]] <= word_q;
  end

  assign bus.WORD_VALID = !empty;
  assign bus.WORD_DATA  = empty ? '0 : mem_q[rptr_q[FIFO_AW-1:0]];
  assign bus.OVERFLOW   = ovf_q;
  assign bus.DROP_COUNT = drop_q;

endmodule

// File: tb/tb_gps_sample_packer.sv
// Scoreboard bench for gps_sample_packer: a queue-based reference tracks words, drops and overflow.
module tb_gps_sample_packer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  bit   rand_ready = 1'b0;

  gps_sample_packer_if gif ();

  gps_sample_packer #(.FIFO_AW(2)) dut (
    .MCU_CLK_25_000 (clk),
    .RST            (rst),
    .bus            (gif)
  );

  always #20 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, stepped once per cycle between clock edges.
  logic [15:0] sb [$];
  int unsigned m_slot;
  logic [15:0] m_word;
  bit          commit_pend;
  logic [15:0] pend_word;
  logic        m_ovf;
  logic [7:0]  m_drop;

  always @(negedge clk) begin
    logic [3:0] nib;
    if (rst) begin
      sb.delete();
      m_slot = 0; m_word = '0; commit_pend = 0; m_ovf = 0; m_drop = '0;
      check_eq("rst_valid", gif.WORD_VALID, 0);
      check_eq("rst_data",  gif.WORD_DATA,  0);
      check_eq("rst_ovf",   gif.OVERFLOW,   0);
      check_eq("rst_drop",  gif.DROP_COUNT, 0);
    end else begin
      check_eq("valid", gif.WORD_VALID, sb.size() != 0);
      if (sb.size() != 0) check_eq("data", gif.WORD_DATA, sb[0]);
      check_eq("ovf",  gif.OVERFLOW,   m_ovf);
      check_eq("drop", gif.DROP_COUNT, m_drop);

      if (sb.size() != 0 && gif.WORD_READY) void'(sb.pop_front());
      if (commit_pend) begin
        commit_pend = 0;
        if (sb.size() < DEPTH) sb.push_back(pend_word);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop++;
        end
      end
      if (gif.GO_NEWDATA) begin
        nib    = {gif.GPS_I1, gif.GPS_I0, gif.GPS_Q1, gif.GPS_Q0};
        m_word = {m_word[11:0], nib};
        if (m_slot == 3) begin
          commit_pend = 1;
          pend_word   = m_word;
        end
        m_slot = (m_slot + 1) % 4;
      end
    end
  end

  task automatic send(input logic [3:0] n);
    @(posedge clk); #1;
    gif.GO_NEWDATA = 1'b1;
    {gif.GPS_I1, gif.GPS_I0, gif.GPS_Q1, gif.GPS_Q0} = n;
    if (rand_ready) gif.WORD_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int unsigned cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      gif.GO_NEWDATA = 1'b0;
      if (rand_ready) gif.WORD_READY = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int unsigned gap);
    for (int i = 3; i >= 0; i--) begin
      send(w[i*4 +: 4]);
      idle(gap);
    end
  endtask

  task automatic drain();
    gif.WORD_READY = 1'b1;
    idle(8);
    gif.WORD_READY = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0;
    rst = 1'b1;
    gif.GO_NEWDATA = 1'b0;
    {gif.GPS_I1, gif.GPS_I0, gif.GPS_Q1, gif.GPS_Q0} = 4'h0;
    gif.WORD_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single word and its 2-cycle latency
    send(4'hA); idle(5); send(4'h5); idle(5); send(4'hF); idle(5); send(4'h0);
    idle(1);
    check_eq("t1_valid_early", gif.WORD_VALID, 0);
    idle(1);
    check_eq("t1_valid", gif.WORD_VALID, 1);
    check_eq("t1_data",  gif.WORD_DATA,  16'hA5F0);
    gif.WORD_READY = 1'b1;
    idle(1);
    gif.WORD_READY = 1'b0;
    check_eq("t1_popped", gif.WORD_VALID, 0);

    // Fill to full, then overflow by one word
    for (int i = 0; i < 16; i++) begin
      send(4'(i)); idle(5);
    end
    idle(2);
    check_eq("t2_head", gif.WORD_DATA, 16'h0123);
    send_word(16'h1111, 5);
    idle(2);
    check_eq("t2_ovf",  gif.OVERFLOW,   1);
    check_eq("t2_drop", gif.DROP_COUNT, 1);
    drain();
    check_eq("t2_empty", gif.WORD_VALID, 0);

    // Commit while full coincides with a pop
    for (int i = 0; i < 4; i++) send_word(16'h2000 + 16'(i), 1);
    idle(2);
    d0 = gif.DROP_COUNT;
    send(4'h9); idle(1); send(4'h8); idle(1); send(4'h7); idle(1); send(4'h6);
    @(posedge clk); #1;
    gif.GO_NEWDATA = 1'b0;
    gif.WORD_READY = 1'b1;
    @(posedge clk); #1;
    gif.WORD_READY = 1'b0;
    idle(1);
    check_eq("t3_drop", gif.DROP_COUNT, 32'(d0));
    check_eq("t3_head", gif.WORD_DATA,  16'h2001);
    drain();

    // Saturating drop counter
    for (int i = 0; i < 304; i++) send_word(16'(i), 1);
    idle(3);
    check_eq("t4_drop", gif.DROP_COUNT, 8'hFF);
    check_eq("t4_ovf",  gif.OVERFLOW,   1);

    // Reset in the middle of a word
    send(4'h7); idle(5); send(4'h8); idle(2);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check_eq("t5_valid", gif.WORD_VALID, 0);
    check_eq("t5_ovf",   gif.OVERFLOW,   0);
    check_eq("t5_drop",  gif.DROP_COUNT, 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    send_word(16'h1234, 5);
    idle(1);
    check_eq("t5_word", gif.WORD_DATA, 16'h1234);
    drain();

    // Random backpressure with back-to-back strobe pairs
    rand_ready = 1'b1;
    for (int w = 0; w < 40; w++) begin
      for (int s = 0; s < 4; s++) begin
        send(4'($urandom_range(0, 15)));
        if (!((w % 5 == 2) && (s == 1))) idle(5);
      end
    end
    rand_ready = 1'b0;
    idle(1);
    drain();
    check_eq("t6_drop",  gif.DROP_COUNT, 0);
    check_eq("t6_empty", gif.WORD_VALID, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
